// File: rtl/johnson_decoder.sv
// ---------------------------------------------------------------------------
// johnson_decoder
//
// Receive-side checker for a WIDTH-stage Johnson (twisted-ring) counter bus.
// Each valid sample is decoded to a binary state index, checked for being a
// legal thermometer code and for being the expected successor of the last
// legal index. After LOCK_CNT consecutive correct steps the decoder reports
// lock.
//
// Ports:
//   clk        single clock, all state on the rising edge
//   r          synchronous active-high reset
//   in_code    sampled Johnson bus, in_code[0] is counter stage 0
//   in_valid   in_code is sampled this cycle
//   err_clr    clears err_cnt (loads 1 if an error is flagged the same edge)
//   state_idx  decoded index of the last valid sample (0 if it was illegal)
//   idx_valid  one-cycle pulse: state_idx updated
//   code_err   one-cycle pulse: last sample was not a legal Johnson code
//   seq_err    one-cycle pulse: last sample legal but not the successor
//   locked     registered copy of (FSM == LOCKED)
//   err_cnt    saturating count of code_err/seq_err pulses
// ---------------------------------------------------------------------------
module johnson_decoder #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned LOCK_CNT   = 4,
   parameter bit          ALLOW_HOLD = 1'b0,
   localparam int         IDXW       = $clog2(2 * WIDTH)
) (
   input  logic              clk,
   input  logic              r,
   input  logic [0:WIDTH-1]  in_code,
   input  logic              in_valid,
   input  logic              err_clr,
   output logic [IDXW-1:0]   state_idx,
   output logic              idx_valid,
   output logic              code_err,
   output logic              seq_err,
   output logic              locked,
   output logic [7:0]        err_cnt
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(2 * WIDTH - 1);
   localparam logic [IDXW-1:0] TOTAL_IDX = IDXW'(2 * WIDTH);
   localparam logic [7:0]      LOCK_TGT  = 8'(LOCK_CNT);

   state_t          state_q, state_d;
   logic [IDXW-1:0] ref_q, ref_d;
   logic [7:0]      good_q, good_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic            idx_valid_q, idx_valid_d;
   logic            code_err_q, code_err_d;
   logic            seq_err_q, seq_err_d;
   logic            locked_q;
   logic [7:0]      err_cnt_q, err_cnt_d;

   // Adjacent-stage transitions; a legal code has at most one.
   logic [WIDTH-2:0] chg;
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_chg
         assign chg[gi] = in_code[gi] ^ in_code[gi+1];
      end
   endgenerate

   logic            legal;
   logic [IDXW-1:0] ones_cnt;
   logic [IDXW-1:0] idx_dec;
   logic [IDXW-1:0] succ_idx;
   logic            is_succ;
   logic            is_hold;
   logic            err_pulse;

   assign legal    = ($countones(chg) <= 1);
   assign ones_cnt = IDXW'($countones(in_code));
   // Last stage set means the 0s-then-1s half: idx = WIDTH + zeros = 2*WIDTH - ones.
   // TOTAL_IDX may wrap to 0 when 2*WIDTH is a power of two; the modular
   // subtraction still yields the right index.
   assign idx_dec  = in_code[WIDTH-1] ? (TOTAL_IDX - ones_cnt) : ones_cnt;
   assign succ_idx = (ref_q == LAST_IDX) ? '0 : (ref_q + IDXW'(1));
   assign is_succ  = (idx_dec == succ_idx);
   assign is_hold  = ALLOW_HOLD && (idx_dec == ref_q);

   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      good_d      = good_q;
      idx_d       = idx_q;
      idx_valid_d = 1'b0;
      code_err_d  = 1'b0;
      seq_err_d   = 1'b0;

      if (in_valid) begin
         idx_valid_d = 1'b1;
         if (!legal) begin
            idx_d      = '0;
            code_err_d = 1'b1;
            state_d    = SEARCH;
            good_d     = '0;
         end else begin
            idx_d = idx_dec;
            ref_d = idx_dec;
            case (state_q)
               SEARCH: begin
                  state_d = TRACK;
                  good_d  = '0;
               end
               TRACK: begin
                  if (is_succ) begin
                     good_d = good_q + 8'd1;
                     if (good_q + 8'd1 == LOCK_TGT) begin
                        state_d = LOCKED;
                     end
                  end else if (!is_hold) begin
                     seq_err_d = 1'b1;
                     good_d    = '0;
                  end
               end
               LOCKED: begin
                  if (!is_succ && !is_hold) begin
                     seq_err_d = 1'b1;
                     state_d   = TRACK;
                     good_d    = '0;
                  end
               end
               default: begin
                  state_d = SEARCH;
                  good_d  = '0;
               end
            endcase
         end
      end
   end

   // Error counter sees the pulse being registered on this same edge, so
   // err_cnt and the pulse become visible together.
   assign err_pulse = code_err_d | seq_err_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = err_pulse ? 8'd1 : 8'd0;
      end else if (err_pulse && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (r) begin
         state_q     <= SEARCH;
         ref_q       <= '0;
         good_q      <= '0;
         idx_q       <= '0;
         idx_valid_q <= 1'b0;
         code_err_q  <= 1'b0;
         seq_err_q   <= 1'b0;
         locked_q    <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         good_q      <= good_d;
         idx_q       <= idx_d;
         idx_valid_q <= idx_valid_d;
         code_err_q  <= code_err_d;
         seq_err_q   <= seq_err_d;
         locked_q    <= (state_q == LOCKED);
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign state_idx = idx_q;
   assign idx_valid = idx_valid_q;
   assign code_err  = code_err_q;
   assign seq_err   = seq_err_q;
   assign locked    = locked_q;
   assign err_cnt   = err_cnt_q;

endmodule
